uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised successor to the single-shot UART transmitter used by the CPU's memory-access stage for stores to the UART address. It adds a write FIFO so the core can issue back-to-back stores without losing characters. It also provides configurable frame format (data bits, parity, stop bits) and status flags (full/empty/busy/count/overflow) for software polling. It sits between the store path and the FPGA `uart_tx` pin and runs on the system clock.

Parameters:
- BAUD_DIV, 868, system clocks per UART bit (100 MHz / 115200); must be ≥ 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥ 2.
- DATA_BITS, 8, data bits per frame; 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- sys_clk_i  in  1  system clock, rising edge.
- sys_rstn_i  in  1  asynchronous active-low reset.
- uart_wr_i  in  1  write strobe, one entry per asserted cycle.
- uart_dat_i  in  DATA_BITS  character to enqueue.
- uart_ovf_clr_i  in  1  clears the sticky overflow flag.
- uart_tx  out  1  serial line, idle high.
- uart_full_o  out  1  FIFO holds FIFO_DEPTH entries.
- uart_empty_o  out  1  FIFO holds 0 entries.
- uart_busy_o  out  1  a frame is being shifted (FSM not IDLE).
- uart_count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- uart_ovf_o  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset (async, on sys_rstn_i low):
  - uart_tx = 1, FIFO pointers and count = 0, empty = 1, full = 0, busy = 0, ovf = 0, FSM = IDLE, baud counter = 0, bit counter = 0.
  - Takes effect immediately, including mid-frame; the partial frame is abandoned and the line goes high at once.
- All outputs are registered; status flags derive from the registered count.
- FIFO write:
  - On an edge with uart_wr_i = 1 and full = 0, uart_dat_i is stored and count increments.
  - If full = 1 on that edge, the data is dropped and ovf is set to 1. This holds even if a pop occurs on the same edge: fullness is evaluated before the pop.
- FIFO pop: occurs only on the FSM frame-load edge (below). A simultaneous accepted write and pop leaves count unchanged.
- ovf:
  - Set by a dropped write; cleared by uart_ovf_clr_i = 1.
  - If set and clear happen on the same edge, set wins.
- Frame format, LSB first:
  - start (0), DATA_BITS data, optional parity bit, then STOP_BITS stop bits (1).
  - Even parity bit = XOR of the data bits; odd parity = its inverse.
  - Each bit holds for exactly BAUD_DIV clocks.
  - Frame length = BAUD_DIV × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) clocks.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: uart_tx = 1. If empty = 0, on the next edge pop the head into the shift register, load the baud counter, go to START; uart_tx = 0 from that edge.
  - START → DATA after BAUD_DIV clocks.
  - DATA shifts DATA_BITS bits, each BAUD_DIV clocks long, then goes to PAR if PARITY≠0, else STOP.
  - PAR → STOP after BAUD_DIV clocks.
  - STOP holds uart_tx = 1 for STOP_BITS × BAUD_DIV clocks. At its final edge: if empty = 0, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: a write accepted on edge k into an empty FIFO while IDLE makes empty = 0 after edge k. The FSM pops on edge k+1, so uart_tx falls at edge k+1.
- busy = 1 in every state except IDLE.
- Data in the FIFO is never altered by later writes until popped; wrap-around of the read and write pointers is modulo FIFO_DEPTH.

Test Plan:
- Single frame (BAUD_DIV=4, PARITY=0, STOP_BITS=1): write 0x55 at edge k → uart_tx=0 for edges k+1..k+4, then the bits 1,0,1,0,1,0,1,0 for 4 clocks each, then 1 for 4 clocks. busy is high for exactly 40 clocks, then IDLE; count goes 1→0 at edge k+1.
- Back-to-back: write 0x01, 0x02, 0x03 on consecutive edges → three contiguous frames totalling 120 clocks, with no high gap between the stop bit and the next start bit; count goes 3→2→1→0 at each frame load.
- Overflow (FIFO_DEPTH=4, BAUD_DIV=4): write 6 bytes on consecutive edges. The first is popped, 4 fill the FIFO (full=1, count=4), and the 6th is dropped with ovf=1. Pulse uart_ovf_clr_i → ovf=0. The transmitted sequence excludes the 6th byte.
- Full + pop collision: with the FIFO full, assert a write on the same edge as a frame-load pop → write dropped, ovf=1, count = FIFO_DEPTH−1.
- Parity: PARITY=1 with 0x07 → parity bit 1; PARITY=2 with 0x07 → 0; PARITY=1 with 0x03 → 0. Also STOP_BITS=2 → stop high for 2×BAUD_DIV clocks.
- Reset mid-frame: deassert sys_rstn_i during the DATA state with 2 entries queued → uart_tx=1 immediately (asynchronously), count=0, empty=1, busy=0. After release, no frame starts until a new write.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Store-path side of the UART transmitter: write strobe, data, overflow
// clear, and the status flags software polls.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 uart_wr_i;
    logic [DATA_BITS-1:0] uart_dat_i;
    logic                 uart_ovf_clr_i;
    logic                 uart_full_o;
    logic                 uart_empty_o;
    logic                 uart_busy_o;
    logic [CW-1:0]        uart_count_o;
    logic                 uart_ovf_o;

    modport master (
        output uart_wr_i, uart_dat_i, uart_ovf_clr_i,
        input  uart_full_o, uart_empty_o, uart_busy_o, uart_count_o, uart_ovf_o
    );

    modport slave (
        input  uart_wr_i, uart_dat_i, uart_ovf_clr_i,
        output uart_full_o, uart_empty_o, uart_busy_o, uart_count_o, uart_ovf_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO, configurable frame format and status flags.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high, waiting for a FIFO entry
// START | start bit (low) for one bit time
// DATA  | shifting data bits LSB first, one bit time each
// PAR   | parity bit for one bit time (only when PARITY != 0)
// STOP  | line high for STOP_BITS bit times; chains straight into START
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           sys_clk_i,
    input  logic           sys_rstn_i,
    uart_tx_fifo_if.slave  bus,
    output logic           uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);
    localparam logic [2:0]    DATA_LOAD = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LOAD = 3'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic          ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count, count_nxt;
    logic                 full_q, empty_q, ovf_q, busy_q, tx_q, tx_nxt;
    logic                 wr_ok, wr_drop, pop;
    logic [DATA_BITS-1:0] head, shift_q, shift_nxt;
    logic                 par_q, par_nxt;
    state_t               state, state_nxt;
    logic [BW-1:0]        baud_cnt, baud_nxt;
    logic [2:0]           bit_cnt, bit_nxt;
    logic                 baud_tc, bit_tc;

    // Fullness is judged on the registered flag, i.e. before any same-edge pop.
    assign wr_ok     = bus.uart_wr_i & ~full_q;
    assign wr_drop   = bus.uart_wr_i & full_q;
    assign head      = mem[rd_ptr];
    assign baud_tc   = (baud_cnt == '0);
    assign bit_tc    = (bit_cnt == 3'd0);
    assign count_nxt = count + CW'(wr_ok) - CW'(pop);

    // Next-state, counter reloads and next line level for the frame sequencer.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_q;
        par_nxt   = par_q;
        tx_nxt    = tx_q;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (!empty_q) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                    baud_nxt  = BAUD_LOAD;
                    shift_nxt = head;
                    par_nxt   = (^head) ^ ODD_PAR;
                    tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    state_nxt = S_DATA;
                    baud_nxt  = BAUD_LOAD;
                    bit_nxt   = DATA_LOAD;
                    tx_nxt    = shift_q[0];
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    baud_nxt = BAUD_LOAD;
                    if (bit_tc) begin
                        if (PARITY != 0) begin
                            state_nxt = S_PAR;
                            tx_nxt    = par_q;
                        end else begin
                            state_nxt = S_STOP;
                            bit_nxt   = STOP_LOAD;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_nxt   = bit_cnt - 3'd1;
                        shift_nxt = shift_q >> 1;
                        tx_nxt    = shift_q[1];
                    end
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            S_PAR: begin
                if (baud_tc) begin
                    state_nxt = S_STOP;
                    baud_nxt  = BAUD_LOAD;
                    bit_nxt   = STOP_LOAD;
                    tx_nxt    = 1'b1;
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    baud_nxt = BAUD_LOAD;
                    if (!bit_tc) begin
                        bit_nxt = bit_cnt - 3'd1;
                    end else if (!empty_q) begin
                        pop       = 1'b1;
                        state_nxt = S_START;
                        shift_nxt = head;
                        par_nxt   = (^head) ^ ODD_PAR;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset abandons any frame and returns the line high.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift_q  <= shift_nxt;
            par_q    <= par_nxt;
            tx_q     <= tx_nxt;
            busy_q   <= (state_nxt != S_IDLE);
        end
    end

    // FIFO pointers, occupancy, flags and sticky overflow (set beats clear).
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            count   <= count_nxt;
            full_q  <= (count_nxt == DEPTH_C);
            empty_q <= (count_nxt == '0);
            if (wr_drop)                 ovf_q <= 1'b1;
            else if (bus.uart_ovf_clr_i) ovf_q <= 1'b0;
        end
    end

    // FIFO storage; entries are only written into free slots.
    always_ff @(posedge sys_clk_i) begin
        if (wr_ok) mem[wr_ptr] <= bus.uart_dat_i;
    end

    assign uart_tx          = tx_q;
    assign bus.uart_full_o  = full_q;
    assign bus.uart_empty_o = empty_q;
    assign bus.uart_busy_o  = busy_q;
    assign bus.uart_count_o = count;
    assign bus.uart_ovf_o   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame-format configurations driven in parallel
// and compared every cycle against a frame-level reference model.
module tb_uart_tx_fifo;
    localparam int NCFG = 3;
    localparam int CFG_BAUD  [NCFG] = '{4, 4, 3};
    localparam int CFG_DEPTH [NCFG] = '{4, 4, 8};
    localparam int CFG_DB    [NCFG] = '{8, 8, 7};
    localparam int CFG_PAR   [NCFG] = '{0, 1, 2};
    localparam int CFG_STOP  [NCFG] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       clr = 1'b0;
    logic       tx0, tx1, tx2;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus0 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus1 ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(8)) bus2 ();

    assign bus0.uart_wr_i = wr;  assign bus0.uart_dat_i = dat;       assign bus0.uart_ovf_clr_i = clr;
    assign bus1.uart_wr_i = wr;  assign bus1.uart_dat_i = dat;       assign bus1.uart_ovf_clr_i = clr;
    assign bus2.uart_wr_i = wr;  assign bus2.uart_dat_i = dat[6:0];  assign bus2.uart_ovf_clr_i = clr;

    uart_tx_fifo #(.BAUD_DIV(4), .FIFO_DEPTH(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .sys_clk_i(clk), .sys_rstn_i(rst_n), .bus(bus0), .uart_tx(tx0));
    uart_tx_fifo #(.BAUD_DIV(4), .FIFO_DEPTH(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
        .sys_clk_i(clk), .sys_rstn_i(rst_n), .bus(bus1), .uart_tx(tx1));
    uart_tx_fifo #(.BAUD_DIV(3), .FIFO_DEPTH(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut2 (
        .sys_clk_i(clk), .sys_rstn_i(rst_n), .bus(bus2), .uart_tx(tx2));

    always #5 clk = ~clk;

    // Reference model: queued bytes, clocks left in the current frame, frame bits.
    logic [7:0]  q [NCFG][$];
    int          left [NCFG];
    logic        ovf_m [NCFG];
    logic [15:0] frame [NCFG];

    function automatic int flen(input int c);
        return CFG_BAUD[c] * (1 + CFG_DB[c] + ((CFG_PAR[c] != 0) ? 1 : 0) + CFG_STOP[c]);
    endfunction

    task automatic check_val(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d @%0t: got %0h, expected %0h", tag, c, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            q[c].delete();
            left[c]  = 0;
            ovf_m[c] = 1'b0;
            frame[c] = '1;
        end
    endtask

    task automatic model_step(input int c);
        int         sz;
        logic       full_b, do_pop;
        logic [7:0] b, d;
        sz     = q[c].size();
        full_b = (sz == CFG_DEPTH[c]);
        do_pop = (sz != 0) && (left[c] <= 1);
        d      = dat & 8'((1 << CFG_DB[c]) - 1);
        if (do_pop) begin
            b        = q[c].pop_front();
            frame[c] = '1;
            frame[c][0] = 1'b0;
            for (int i = 0; i < CFG_DB[c]; i++) frame[c][1 + i] = b[i];
            if (CFG_PAR[c] != 0) frame[c][1 + CFG_DB[c]] = (^b) ^ (CFG_PAR[c] == 2);
            left[c] = flen(c);
        end else if (left[c] > 0) begin
            left[c]--;
        end
        if (wr) begin
            if (full_b) ovf_m[c] = 1'b1;
            else        q[c].push_back(d);
        end
        if (clr && !(wr && full_b)) ovf_m[c] = 1'b0;
    endtask

    task automatic check_all();
        logic       o_tx, o_full, o_empty, o_busy, o_ovf, e_tx;
        logic [3:0] o_cnt;
        for (int c = 0; c < NCFG; c++) begin
            case (c)
                0: begin o_tx = tx0; o_cnt = 4'(bus0.uart_count_o); o_full = bus0.uart_full_o;
                          o_empty = bus0.uart_empty_o; o_busy = bus0.uart_busy_o; o_ovf = bus0.uart_ovf_o; end
                1: begin o_tx = tx1; o_cnt = 4'(bus1.uart_count_o); o_full = bus1.uart_full_o;
                          o_empty = bus1.uart_empty_o; o_busy = bus1.uart_busy_o; o_ovf = bus1.uart_ovf_o; end
                default: begin o_tx = tx2; o_cnt = 4'(bus2.uart_count_o); o_full = bus2.uart_full_o;
                          o_empty = bus2.uart_empty_o; o_busy = bus2.uart_busy_o; o_ovf = bus2.uart_ovf_o; end
            endcase
            e_tx = (left[c] == 0) ? 1'b1 : frame[c][(flen(c) - left[c]) / CFG_BAUD[c]];
            check_val("tx",    c, 32'(o_tx),    32'(e_tx));
            check_val("count", c, 32'(o_cnt),   32'(q[c].size()));
            check_val("full",  c, 32'(o_full),  32'(q[c].size() == CFG_DEPTH[c]));
            check_val("empty", c, 32'(o_empty), 32'(q[c].size() == 0));
            check_val("busy",  c, 32'(o_busy),  32'(left[c] != 0));
            check_val("ovf",   c, 32'(o_ovf),   32'(ovf_m[c]));
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, check at the falling edge.
    task automatic tick(input logic w, input logic [7:0] d, input logic cl);
        wr  = w;
        dat = d;
        clr = cl;
        @(posedge clk);
        for (int c = 0; c < NCFG; c++) model_step(c);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] burst [6];
        int guard;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // Single frame 0x55: count 1 after the write edge, popped on the next.
        tick(1'b1, 8'h55, 1'b0);
        check_val("sf_cnt_k",  0, 32'(bus0.uart_count_o), 32'd1);
        check_val("sf_tx_k",   0, 32'(tx0), 32'd1);
        tick(1'b0, 8'h00, 1'b0);
        check_val("sf_cnt_k1", 0, 32'(bus0.uart_count_o), 32'd0);
        check_val("sf_tx_k1",  0, 32'(tx0), 32'd0);
        check_val("sf_busy",   0, 32'(bus0.uart_busy_o), 32'd1);
        idle(60);

        // Back-to-back frames.
        tick(1'b1, 8'h01, 1'b0);
        tick(1'b1, 8'h02, 1'b0);
        tick(1'b1, 8'h03, 1'b0);
        idle(160);

        // Parity patterns.
        tick(1'b1, 8'h07, 1'b0);
        tick(1'b1, 8'h03, 1'b0);
        idle(120);

        // Overflow: six consecutive writes, then clear.
        for (int i = 0; i < 6; i++) burst[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) tick(1'b1, burst[i], 1'b0);
        check_val("ovf_set",  0, 32'(bus0.uart_ovf_o), 32'd1);
        check_val("ovf_full", 0, 32'(bus0.uart_full_o), 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        check_val("ovf_clr",  0, 32'(bus0.uart_ovf_o), 32'd0);
        idle(300);

        // Full FIFO with a write landing on the frame-load pop edge.
        for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom), 1'b0);
        guard = 0;
        while (left[0] != 1 && guard < 200) begin
            tick(1'b0, 8'h00, 1'b0);
            guard++;
        end
        check_val("coll_reach", 0, 32'(left[0]), 32'd1);
        tick(1'b1, 8'hA5, 1'b0);
        check_val("coll_ovf", 0, 32'(bus0.uart_ovf_o), 32'd1);
        check_val("coll_cnt", 0, 32'(bus0.uart_count_o), 32'd3);
        tick(1'b0, 8'h00, 1'b1);
        idle(320);

        // Random traffic: sparse, then dense enough to overflow.
        for (int i = 0; i < 1200; i++)
            tick(1'($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom_range(0, 31) == 0));
        for (int i = 0; i < 300; i++)
            tick(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 15) == 0));
        idle(400);

        // Reset mid-frame with entries still queued.
        tick(1'b1, 8'h3C, 1'b0);
        tick(1'b1, 8'hC3, 1'b0);
        tick(1'b1, 8'h5A, 1'b0);
        idle(10);
        check_val("mid_cnt", 0, 32'(bus0.uart_count_o), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_tx",    0, 32'(tx0), 32'd1);
        check_val("rst_cnt",   0, 32'(bus0.uart_count_o), 32'd0);
        check_val("rst_empty", 0, 32'(bus0.uart_empty_o), 32'd1);
        check_val("rst_busy",  0, 32'(bus0.uart_busy_o), 32'd0);
        check_val("rst_tx",    1, 32'(tx1), 32'd1);
        check_val("rst_tx",    2, 32'(tx2), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        idle(30);
        tick(1'b1, 8'h81, 1'b0);
        idle(80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
